// File: rtl/gecikmeli_bellek_modeli.sv
// Pipelined word memory responder: fixed latency, byte-masked writes,
// in-order responses through a small circular queue with backpressure.
module gecikmeli_bellek_modeli #(
   parameter int                   VERI_BIT          = 32,
   parameter int                   ADRES_BIT         = 32,
   parameter int                   BELLEK_SOZCUK     = 1024,
   parameter logic [ADRES_BIT-1:0] ADRES_MASKE       = 32'h0000_ffff,
   parameter int                   GECIKME           = 5,
   parameter int                   MAKS_BEKLEYEN     = 4,
   parameter bit                   YAZ_YANIT_VAR     = 1'b1,
   parameter string                BASLANGIC_DOSYASI = ""
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADRES_BIT-1:0]  istek_adres_i,
   input  logic [VERI_BIT-1:0]   istek_veri_i,
   input  logic [VERI_BIT/8-1:0] istek_maske_i,
   input  logic                  istek_yaz_i,
   input  logic                  istek_gecerli_i,
   output logic                  istek_hazir_o,
   output logic [VERI_BIT-1:0]   yanit_veri_o,
   output logic                  yanit_hata_o,
   output logic                  yanit_gecerli_o,
   input  logic                  yanit_hazir_i
);

   localparam int BAYT     = VERI_BIT / 8;
   localparam int BAYT_LOG = $clog2(BAYT);
   localparam int IW = (BELLEK_SOZCUK > 1) ? $clog2(BELLEK_SOZCUK) : 1;
   localparam int PW = (MAKS_BEKLEYEN > 1) ? $clog2(MAKS_BEKLEYEN) : 1;
   localparam int BW = $clog2(MAKS_BEKLEYEN) + 1;
   localparam int YW = $clog2(GECIKME + 1);

   logic [VERI_BIT-1:0]  mem    [BELLEK_SOZCUK];
   logic [VERI_BIT-1:0]  veri_q [MAKS_BEKLEYEN];
   logic                 hata_q [MAKS_BEKLEYEN];
   logic [YW-1:0]        yas_q  [MAKS_BEKLEYEN];

   logic [PW-1:0]        yaz_ptr;
   logic [PW-1:0]        oku_ptr;
   logic [BW-1:0]        bekleyen;
   logic [BW-1:0]        bekleyen_d;
   logic                 hazir_q;
   logic [ADRES_BIT-1:0] idx;
   logic                 aralik_disi;
   logic                 kabul;
   logic                 itme;
   logic                 cekme;
   logic [VERI_BIT-1:0]  okunan;

   assign idx         = (istek_adres_i & ADRES_MASKE) >> BAYT_LOG;
   assign aralik_disi = idx >= ADRES_BIT'(BELLEK_SOZCUK);

   // hazir_q itself is registered; rst_i only masks it while reset is held
   assign istek_hazir_o = hazir_q & ~rst_i;
   assign kabul = istek_gecerli_i & istek_hazir_o;
   assign itme  = kabul & (~istek_yaz_i | YAZ_YANIT_VAR);

   assign yanit_gecerli_o = (bekleyen != '0) &&
                            (yas_q[oku_ptr] == YW'(GECIKME));
   assign cekme        = yanit_gecerli_o & yanit_hazir_i;
   assign yanit_veri_o = yanit_gecerli_o ? veri_q[oku_ptr] : '0;
   assign yanit_hata_o = yanit_gecerli_o & hata_q[oku_ptr];

   assign okunan = (istek_yaz_i | aralik_disi) ? '0
                                               : mem[idx[IW-1:0]];

   function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
      return (p == PW'(MAKS_BEKLEYEN - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      bekleyen_d = bekleyen;
      if (itme && !cekme) begin
         bekleyen_d = bekleyen + 1'b1;
      end else if (!itme && cekme) begin
         bekleyen_d = bekleyen - 1'b1;
      end
   end

   // memory has no reset so contents survive a mid-run reset
   always_ff @(posedge clk_i) begin
      if (kabul && istek_yaz_i && !aralik_disi) begin
         for (int b = 0; b < BAYT; b++) begin
            if (istek_maske_i[b]) begin
               mem[idx[IW-1:0]][b*8 +: 8] <= istek_veri_i[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         yaz_ptr  <= '0;
         oku_ptr  <= '0;
         bekleyen <= '0;
         hazir_q  <= 1'b1;
         for (int i = 0; i < MAKS_BEKLEYEN; i++) begin
            veri_q[i] <= '0;
            hata_q[i] <= 1'b0;
            yas_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < MAKS_BEKLEYEN; i++) begin
            if (yas_q[i] != YW'(GECIKME)) begin
               yas_q[i] <= yas_q[i] + 1'b1;
            end
         end
         if (itme) begin
            veri_q[yaz_ptr] <= okunan;
            hata_q[yaz_ptr] <= aralik_disi;
            yas_q[yaz_ptr]  <= YW'(1);
            yaz_ptr         <= sonraki(yaz_ptr);
         end
         if (cekme) begin
            oku_ptr <= sonraki(oku_ptr);
         end
         bekleyen <= bekleyen_d;
         hazir_q  <= bekleyen_d < BW'(MAKS_BEKLEYEN);
      end
   end

endmodule
